// File: rtl/maze_pkg.sv
// Shared types and constants for the maze store.
// Holds the default index width, the dimension helper, the FSM states and the cell encoding.
package maze_pkg;

  localparam int MAZE_WIDTH = 6;

  function automatic int maze_dim(input int width);
    return 1 << width;
  endfunction

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic WALL = 1'b1;
  localparam logic FREE = 1'b0;

endpackage

// File: rtl/maze_bitplane.sv
// Square bit array with whole-plane clear, row write, single-bit set, registered bit and row reads.
// Reads see the array contents before any write or set on the same edge; clear wins over everything.
module maze_bitplane
  import maze_pkg::*;
#(
  parameter int width = MAZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  row_we,
  input  logic [width-1:0]      row_idx,
  input  logic [2**width-1:0]   row_data,
  input  logic                  set_en,
  input  logic [width-1:0]      set_row,
  input  logic [width-1:0]      set_col,
  output logic                  peek,
  input  logic                  rd_preset,
  input  logic                  rd_en,
  input  logic [width-1:0]      rd_row,
  input  logic [width-1:0]      rd_col,
  output logic                  rd_bit,
  input  logic [width-1:0]      row_sel,
  output logic [2**width-1:0]   row_bits
);

  localparam int DIM = maze_dim(width);

  logic [DIM-1:0] mem [DIM];

  // Current value of the set target, used to tell a fresh mark from a repeat.
  assign peek = mem[set_row][set_col];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DIM; i++) begin
        mem[i] <= {DIM{FREE}};
      end
    end else begin
      if (row_we) begin
        mem[row_idx] <= row_data;
      end
      if (set_en) begin
        mem[set_row][set_col] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_preset) begin
      rd_bit <= WALL;
    end else if (rd_en) begin
      rd_bit <= mem[rd_row][rd_col];
    end
  end

  // Clearing also blanks the registered row so stale marks never show after a clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      row_bits <= '0;
    end else begin
      row_bits <= mem[row_sel];
    end
  end

endmodule

// File: rtl/maze_store.sv
// Maze wall store loaded row by row, serving 1-cycle cell reads and recording path marks.
// Optional distinct-mark counter path_len is built when MAZE_PATH_COUNT_EN is defined.
module maze_store
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [2**maze_width-1:0]    load_data,
  input  logic                        reload,
  output logic                        maze_ready,
  input  logic [maze_width-1:0]       row,
  input  logic [maze_width-1:0]       col,
  input  logic                        maze_oe,
  input  logic                        maze_we,
  output logic                        maze_in,
  input  logic [maze_width-1:0]       path_row_sel,
  output logic [2**maze_width-1:0]    path_row_bits
`ifdef MAZE_PATH_COUNT_EN
  ,
  output logic [2*maze_width:0]       path_len
`endif
);

  state_t                  state;
  state_t                  state_nxt;
  logic [maze_width-1:0]   ptr;
  logic [maze_width-1:0]   ptr_nxt;
  logic                    accept;
  logic                    reload_take;
  logic                    serving;
  logic                    rd_preset;
  logic                    rd_en;
  logic                    plane_clr;
  logic                    mark_req;
  logic                    path_hit;
  logic                    new_mark;
  logic                    wall_peek_unused;
  logic [2**maze_width-1:0] wall_row_unused;
  logic                    path_rd_unused;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    accept      = 1'b0;
    reload_take = 1'b0;
    load_ready  = (state == ST_LOAD);
    maze_ready  = (state == ST_SERVE);
    case (state)
      ST_LOAD: begin
        if (load_valid) begin
          accept  = 1'b1;
          ptr_nxt = ptr + 1'b1;
          if (&ptr) begin
            state_nxt = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (reload) begin
          reload_take = 1'b1;
          state_nxt   = ST_LOAD;
          ptr_nxt     = '0;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // A reload cycle swallows any access issued alongside it.
  assign serving   = (state == ST_SERVE);
  assign rd_preset = rst | ((state == ST_LOAD) & maze_oe) | reload_take;
  assign rd_en     = serving & maze_oe & ~reload;
  assign mark_req  = serving & maze_we & ~reload;
  assign new_mark  = mark_req & ~path_hit;
  assign plane_clr = rst | reload_take;

  maze_bitplane #(.width(maze_width)) u_wall (
    .clk       (clk),
    .clr       (1'b0),
    .row_we    (accept),
    .row_idx   (ptr),
    .row_data  (load_data),
    .set_en    (1'b0),
    .set_row   ('0),
    .set_col   ('0),
    .peek      (wall_peek_unused),
    .rd_preset (rd_preset),
    .rd_en     (rd_en),
    .rd_row    (row),
    .rd_col    (col),
    .rd_bit    (maze_in),
    .row_sel   ('0),
    .row_bits  (wall_row_unused)
  );

  maze_bitplane #(.width(maze_width)) u_path (
    .clk       (clk),
    .clr       (plane_clr),
    .row_we    (1'b0),
    .row_idx   ('0),
    .row_data  ('0),
    .set_en    (new_mark),
    .set_row   (row),
    .set_col   (col),
    .peek      (path_hit),
    .rd_preset (1'b0),
    .rd_en     (1'b0),
    .rd_row    ('0),
    .rd_col    ('0),
    .rd_bit    (path_rd_unused),
    .row_sel   (path_row_sel),
    .row_bits  (path_row_bits)
  );

`ifdef MAZE_PATH_COUNT_EN
  localparam logic [2*maze_width:0] LEN_MAX = {1'b1, {(2*maze_width){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst || reload_take) begin
      path_len <= '0;
    end else if (new_mark && (path_len != LEN_MAX)) begin
      path_len <= path_len + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_maze_store.sv
// Bench for maze_store at maze_width=3: directed vectors plus random traffic against a cell-level model.
module tb_maze_store;

  localparam int W = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [N-1:0] load_data;
  logic         reload;
  logic         maze_ready;
  logic [W-1:0] row;
  logic [W-1:0] col;
  logic         maze_oe;
  logic         maze_we;
  logic         maze_in;
  logic [W-1:0] path_row_sel;
  logic [N-1:0] path_row_bits;
`ifdef MAZE_PATH_COUNT_EN
  logic [2*W:0] path_len;
`endif

  always #5 clk = ~clk;

  maze_store #(.maze_width(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .reload        (reload),
    .maze_ready    (maze_ready),
    .row           (row),
    .col           (col),
    .maze_oe       (maze_oe),
    .maze_we       (maze_we),
    .maze_in       (maze_in),
    .path_row_sel  (path_row_sel),
    .path_row_bits (path_row_bits)
`ifdef MAZE_PATH_COUNT_EN
    ,
    .path_len      (path_len)
`endif
  );

  // Reference model: whole-maze arrays updated once per clock from the rules.
  logic [N-1:0] m_wall [N];
  logic [N-1:0] m_path [N];
  bit           m_loaded;
  int           m_ptr;
  logic         m_in;
  logic [N-1:0] m_prb;
  int           m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_loaded = 0;
    m_ptr    = 0;
    m_in     = 1'b1;
    m_prb    = '0;
    m_cnt    = 0;
    for (int i = 0; i < N; i++) m_path[i] = '0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_clear();
    end else if (!m_loaded) begin
      m_prb = m_path[path_row_sel];
      if (maze_oe) m_in = 1'b1;
      if (load_valid) begin
        m_wall[m_ptr] = load_data;
        if (m_ptr == N - 1) m_loaded = 1;
        m_ptr = (m_ptr + 1) % N;
      end
    end else if (reload) begin
      model_clear();
    end else begin
      m_prb = m_path[path_row_sel];
      if (maze_oe) m_in = m_wall[row][col];
      if (maze_we) begin
        if (m_path[row][col] == 1'b0 && m_cnt < N * N) m_cnt++;
        m_path[row][col] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("load_ready", {31'd0, load_ready}, {31'd0, !m_loaded});
    chk("maze_ready", {31'd0, maze_ready}, {31'd0, m_loaded});
    chk("maze_in", {31'd0, maze_in}, {31'd0, m_in});
    chk("path_row_bits", {24'd0, path_row_bits}, {24'd0, m_prb});
`ifdef MAZE_PATH_COUNT_EN
    chk("path_len", {25'd0, path_len}, m_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    rst = 0; load_valid = 0; reload = 0; maze_oe = 0; maze_we = 0;
  endtask

  task automatic load_beat(input logic [N-1:0] d);
    load_valid = 1;
    load_data  = d;
    tick();
    load_valid = 0;
  endtask

  typedef struct {
    logic         oe;
    logic         we;
    logic [W-1:0] r;
    logic [W-1:0] c;
    logic         exp_in;
    logic [N-1:0] exp_prb;
  } vec_t;

  vec_t vt [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 3'd3, 3'd0, 1'b1, 8'h00};
    vt[1] = '{1'b1, 1'b0, 3'd3, 3'd3, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 8'h00};
    vt[4] = '{1'b0, 1'b1, 3'd3, 3'd4, 1'b0, 8'h08};
    vt[5] = '{1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 8'h18};
    vt[6] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'h18};
    vt[7] = '{1'b1, 1'b1, 3'd3, 3'd4, 1'b0, 8'h18};

    idle();
    rst = 1; load_data = '0; row = '0; col = '0; path_row_sel = 3'd3;
    tick();
    tick();
    rst = 0;
    chk("reset_load_ready", {31'd0, load_ready}, 32'd1);
    chk("reset_maze_ready", {31'd0, maze_ready}, 32'd0);
    chk("reset_maze_in", {31'd0, maze_in}, 32'd1);
    chk("reset_path_row", {24'd0, path_row_bits}, 32'd0);

    // Load with a 5-cycle stall between rows 2 and 3.
    for (int r = 0; r < N; r++) begin
      if (r == 3) begin
        repeat (5) tick();
        chk("stall_still_loading", {31'd0, load_ready}, 32'd1);
      end
      load_beat((r == 3) ? 8'b1110_0111 : 8'hFF);
      if (r < N - 1) chk("mid_load_not_ready", {31'd0, maze_ready}, 32'd0);
    end
    chk("load_done_ready", {31'd0, maze_ready}, 32'd1);
    chk("load_done_load_ready", {31'd0, load_ready}, 32'd0);

    // Extra beat while serving must be ignored.
    load_beat(8'h00);

    for (int i = 0; i < 8; i++) begin
      maze_oe = vt[i].oe; maze_we = vt[i].we; row = vt[i].r; col = vt[i].c;
      tick();
      chk($sformatf("vec%0d_maze_in", i), {31'd0, maze_in}, {31'd0, vt[i].exp_in});
      chk($sformatf("vec%0d_path_row", i), {24'd0, path_row_bits}, {24'd0, vt[i].exp_prb});
    end
    idle();
    tick();
    chk("marks_after_same_cycle", {24'd0, path_row_bits}, 32'h18);
`ifdef MAZE_PATH_COUNT_EN
    chk("path_len_distinct", {25'd0, path_len}, 32'd2);
`endif

    // Reload with a simultaneous access that must be dropped.
    reload = 1; maze_oe = 1; maze_we = 1; row = 3'd2; col = 3'd2;
    tick();
    idle();
    tick();
    chk("reload_path_row", {24'd0, path_row_bits}, 32'd0);
    chk("reload_maze_ready", {31'd0, maze_ready}, 32'd0);
    chk("reload_load_ready", {31'd0, load_ready}, 32'd1);
    chk("reload_maze_in", {31'd0, maze_in}, 32'd1);

    // Reset after 4 beats abandons the partial load.
    for (int r = 0; r < 4; r++) load_beat(8'(r * 37));
    rst = 1;
    tick();
    rst = 0;
    for (int r = 0; r < N - 1; r++) load_beat(8'($urandom));
    chk("partial_after_rst", {31'd0, maze_ready}, 32'd0);
    load_beat(8'($urandom));
    chk("full_after_rst", {31'd0, maze_ready}, 32'd1);

    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 299) == 0);
      reload       = ($urandom_range(0, 39) == 0);
      load_valid   = $urandom_range(0, 1) == 1;
      load_data    = 8'($urandom);
      maze_oe      = $urandom_range(0, 1) == 1;
      maze_we      = $urandom_range(0, 2) == 0;
      row          = 3'($urandom);
      col          = 3'($urandom);
      path_row_sel = 3'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
